// File: rtl/split_pkg.sv
// Shared definitions for the split_stream constraint loader: FSM state
// encoding and the default geometry of one solve.
package split_pkg;

  localparam int unsigned NUM_VARS_DEF = 30;
  localparam int unsigned MAX_W_DEF    = 32;
  localparam int unsigned IDX_W_DEF    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : split_pkg

// File: rtl/split_stream_if.sv
// Variable-beat stream between a producer (master) and split_stream (slave).
interface split_stream_if
  import split_pkg::*;
#(
  parameter int unsigned MAX_W = MAX_W_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [MAX_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_idx,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_idx,
    input  in_data,
    output in_ready
  );

endinterface : split_stream_if

// File: rtl/split_bitmap.sv
// Loaded-variable bitmap for split_stream. Reports whether the presented
// index is already loaded and whether the bitmap is complete once the
// pending set (if any) lands. Out-of-range indices map to an empty mask.
module split_bitmap
  import split_pkg::*;
#(
  parameter int unsigned NUM_VARS = NUM_VARS_DEF,
  parameter int unsigned IDX_W    = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             set_en,
  input  logic [IDX_W-1:0] idx,
  output logic             dup_hit_c,
  output logic             all_loaded_c
);

  logic [NUM_VARS-1:0] bitmap_q;
  logic [NUM_VARS-1:0] onehot_c;
  logic [NUM_VARS-1:0] pending_c;

  // One-hot of the presented index; shifts past the top give zero.
  always_comb begin
    onehot_c  = NUM_VARS'(1) << idx;
    pending_c = set_en ? onehot_c : '0;
  end

  assign dup_hit_c    = |(bitmap_q & onehot_c);
  assign all_loaded_c = &(bitmap_q | pending_c);

  // Bitmap register: cleared by a new solve, otherwise accumulates sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_q <= '0;
    end else if (clr) begin
      bitmap_q <= '0;
    end else if (set_en) begin
      bitmap_q <= bitmap_q | onehot_c;
    end
  end

endmodule : split_bitmap

// File: rtl/split_stream.sv
// split_stream: collects NUM_VARS indexed variable words per solve, flags
// duplicate and out-of-range indices, and reports a constraint result two
// cycles after the final new variable is accepted.
// Optional feature macro: SPLIT_PARITY_CHK_EN -- when defined, x is the
// comparison of the running XOR of all accepted variable bits against
// PARITY_TARGET; when undefined, x is constantly 1 in DONE.
module split_stream
  import split_pkg::*;
#(
  parameter int unsigned NUM_VARS      = NUM_VARS_DEF,
  parameter int unsigned MAX_W         = MAX_W_DEF,
  parameter int unsigned IDX_W         = IDX_W_DEF,
  parameter logic        PARITY_TARGET = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  split_stream_if.slave  bus,
  output logic           done_valid,
  output logic           x,
  output logic           err_dup,
  output logic           err_idx
);

  state_e           state_q;
  state_e           state_d;

  logic [IDX_W-1:0] idx_c;
  logic [MAX_W-1:0] data_c;
  logic             ready_c;
  logic             accept_c;
  logic             idx_ok_c;
  logic             dup_hit_c;
  logic             new_beat_c;
  logic             all_loaded_c;
  logic             pass_c;

  logic             done_d;
  logic             x_d;
  logic             err_dup_d;
  logic             err_idx_d;

  assign idx_c  = bus.in_idx;
  assign data_c = bus.in_data;

  // Beats are taken only while loading and never in a restart cycle.
  assign ready_c      = (state_q == LOAD) && !start;
  assign bus.in_ready = ready_c;

  // Beat classification: transfer, index range and first-time load.
  always_comb begin
    accept_c   = bus.in_valid && ready_c;
    idx_ok_c   = 32'(idx_c) < NUM_VARS;
    new_beat_c = accept_c && idx_ok_c && !dup_hit_c;
  end

  split_bitmap #(
    .NUM_VARS (NUM_VARS),
    .IDX_W    (IDX_W)
  ) u_bitmap (
    .clk          (clk),
    .rst          (rst),
    .clr          (start),
    .set_en       (new_beat_c),
    .idx          (idx_c),
    .dup_hit_c    (dup_hit_c),
    .all_loaded_c (all_loaded_c)
  );

`ifdef SPLIT_PARITY_CHK_EN
  logic par_q;

  // Running XOR of every bit of each newly loaded variable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (start) begin
      par_q <= 1'b0;
    end else if (new_beat_c) begin
      par_q <= par_q ^ (^data_c);
    end
  end

  assign pass_c = (par_q == PARITY_TARGET);
`else
  logic unused_data_c;

  // Data and target do not influence the result without the parity check.
  assign unused_data_c = ^{data_c, PARITY_TARGET};
  assign pass_c        = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next registered outputs; start always opens a new solve.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    x_d       = 1'b0;
    err_dup_d = err_dup;
    err_idx_d = err_idx;

    unique case (state_q)
      IDLE: state_d = IDLE;
      LOAD: if (new_beat_c && all_loaded_c) state_d = EVAL;
      EVAL: state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = LOAD;
    end

    done_d = (state_d == DONE);
    x_d    = done_d && pass_c;

    if (start) begin
      err_dup_d = 1'b0;
      err_idx_d = 1'b0;
    end else begin
      if (accept_c && idx_ok_c && dup_hit_c) err_dup_d = 1'b1;
      if (accept_c && !idx_ok_c)             err_idx_d = 1'b1;
    end
  end

  // Registered result and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_valid <= 1'b0;
      x          <= 1'b0;
      err_dup    <= 1'b0;
      err_idx    <= 1'b0;
    end else begin
      done_valid <= done_d;
      x          <= x_d;
      err_dup    <= err_dup_d;
      err_idx    <= err_idx_d;
    end
  end

endmodule : split_stream

// File: tb/tb_split_stream.sv
// Bench for split_stream: stimulus pushes expected per-solve results into a
// queue; a negedge monitor pops and compares whenever done_valid rises.
module tb_split_stream;

  localparam int unsigned NV = 30;
  localparam int unsigned MW = 32;
  localparam int unsigned IW = 5;
  localparam logic        PT = 1'b0;

  typedef struct {
    logic x;
    logic dup;
    logic bad;
    int   nbeats;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic done_valid;
  logic x;
  logic err_dup;
  logic err_idx;

  split_stream_if #(.MAX_W(MW), .IDX_W(IW)) bus ();

  split_stream #(
    .NUM_VARS      (NV),
    .MAX_W         (MW),
    .IDX_W         (IW),
    .PARITY_TARGET (PT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .done_valid (done_valid),
    .x          (x),
    .err_dup    (err_dup),
    .err_idx    (err_idx)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference model of one solve: set of loaded indices and data parity.
  bit   loaded[NV];
  int   nloaded;
  int   nbeats;
  logic par;
  logic e_dup;
  logic e_bad;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    foreach (loaded[i]) loaded[i] = 1'b0;
    nloaded = 0;
    nbeats  = 0;
    par     = 1'b0;
    e_dup   = 1'b0;
    e_bad   = 1'b0;
  endfunction

  function automatic void model_beat(int idx, logic [31:0] d);
    exp_t e;
    nbeats++;
    if (idx >= int'(NV)) begin
      e_bad = 1'b1;
    end else if (loaded[idx]) begin
      e_dup = 1'b1;
    end else begin
      loaded[idx] = 1'b1;
      nloaded++;
      par = par ^ (^d);
      if (nloaded == int'(NV)) begin
`ifdef SPLIT_PARITY_CHK_EN
        e.x = (par == PT);
`else
        e.x = 1'b1;
`endif
        e.dup    = e_dup;
        e.bad    = e_bad;
        e.nbeats = nbeats;
        sb.push_back(e);
      end
    end
  endfunction

  // Monitor: counts accepted beats per solve and checks each result.
  int   cyc       = 0;
  int   last_acc  = 0;
  int   acc_cnt   = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      acc_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      if (start) acc_cnt = 0;
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        last_acc = cyc;
      end
      if (done_valid && !prev_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("x", 32'(x), 32'(e.x));
          chk("err_dup", 32'(err_dup), 32'(e.dup));
          chk("err_idx", 32'(err_idx), 32'(e.bad));
          chk("beats_per_solve", 32'(acc_cnt), 32'(e.nbeats));
          chk("done_latency", 32'(cyc - last_acc), 32'(2));
        end
      end
      prev_done = done_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(int idx, logic [31:0] d);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_idx   = IW'(idx);
    bus.in_data  = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("beat_accepted", 32'(ok), 32'(1));
    if (ok) model_beat(idx, d);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic do_start(bit with_valid, int idx);
    start = 1'b1;
    if (with_valid) begin
      bus.in_valid = 1'b1;
      bus.in_idx   = IW'(idx);
      bus.in_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("ready_low_on_start", 32'(bus.in_ready), 32'(0));
    end
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = done_valid;
    end
    chk("done_seen", 32'(seen), 32'(1));
    tick();
    repeat (2) begin
      @(negedge clk);
      chk("done_held", 32'(done_valid), 32'(1));
      tick();
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.in_data  = '0;
    repeat (2) tick();
    rst = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic random_solve();
    int order[NV];
    logic [31:0] d;
    int w;
    foreach (order[i]) order[i] = i;
    for (int i = int'(NV) - 1; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    do_start(1'b0, 0);
    for (int i = 0; i < int'(NV); i++) begin
      if (i > 0 && $urandom_range(0, 5) == 0)
        send_beat(order[$urandom_range(0, i - 1)], $urandom);
      if ($urandom_range(0, 7) == 0)
        send_beat(int'($urandom_range(NV, 31)), $urandom);
      w = int'($urandom_range(1, 32));
      d = $urandom;
      if (w < 32) d = d & ((32'h1 << w) - 32'h1);
      send_beat(order[i], d);
    end
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    chk("rst_done", 32'(done_valid), 32'(0));
    chk("rst_x", 32'(x), 32'(0));
    chk("rst_err_dup", 32'(err_dup), 32'(0));
    chk("rst_err_idx", 32'(err_idx), 32'(0));

    // Beats offered in IDLE are not taken.
    bus.in_valid = 1'b1;
    bus.in_idx   = IW'(0);
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready_low", 32'(bus.in_ready), 32'(0));
      tick();
    end
    bus.in_valid = 1'b0;

    // All variables equal 1.
    do_start(1'b0, 0);
    for (int i = 0; i < int'(NV); i++) send_beat(i, 32'h1);
    wait_done();

    // Index 5 carries an even-parity word; start from DONE.
    do_start(1'b0, 0);
    @(negedge clk);
    chk("done_cleared_by_start", 32'(done_valid), 32'(0));
    tick();
    for (int i = 0; i < int'(NV); i++) send_beat(i, (i == 5) ? 32'h3 : 32'h1);
    wait_done();

    // Duplicate index 7 with all-ones data.
    do_start(1'b0, 0);
    for (int i = 0; i < int'(NV); i++) begin
      send_beat(i, 32'h1);
      if (i == 10) send_beat(7, 32'hFFFF_FFFF);
    end
    wait_done();

    // Out-of-range index plus a duplicate, then asynchronous reset in DONE.
    do_start(1'b0, 0);
    for (int i = 0; i < int'(NV); i++) begin
      if (i == 3) send_beat(31, 32'h1);
      if (i == 20) send_beat(2, 32'h7);
      send_beat(i, 32'h1);
    end
    wait_done();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_done", 32'(done_valid), 32'(0));
    chk("async_rst_x", 32'(x), 32'(0));
    chk("async_rst_err_dup", 32'(err_dup), 32'(0));
    chk("async_rst_err_idx", 32'(err_idx), 32'(0));
    chk("async_rst_ready", 32'(bus.in_ready), 32'(0));
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    chk("post_rst_ready", 32'(bus.in_ready), 32'(0));
    chk("post_rst_done", 32'(done_valid), 32'(0));

    // Restart with a beat offered in the start cycle after 10 beats.
    do_start(1'b0, 0);
    for (int i = 0; i < 10; i++) send_beat(i, $urandom);
    do_start(1'b1, 10);
    for (int i = int'(NV) - 1; i >= 0; i--) send_beat(i, $urandom);
    wait_done();

    // Reset mid-LOAD discards partial load.
    do_start(1'b0, 0);
    for (int i = 0; i < 15; i++) send_beat(i, $urandom);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    do_start(1'b0, 0);
    for (int i = 0; i < int'(NV); i++) send_beat(i, $urandom);
    wait_done();

    repeat (6) random_solve();

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_split_stream
